// File: rtl/bin_to_bcd4.sv
// Sequential double-dabble converter: BIN_W-bit unsigned binary to four packed BCD digits.
// Optional leading-zero blank mask enabled by defining LEADING_ZERO_BLANK_EN.
module bin_to_bcd4 #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd_out,
  output logic             ovf,
  output logic [3:0]       blank
);

  localparam logic [31:0] MAX_BCD  = 32'd9999;
  localparam logic [3:0]  CNT_INIT = 4'(BIN_W);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [BIN_W-1:0] opnd, opnd_nx;
  logic [15:0]      scratch, scratch_nx;
  logic [3:0]       cnt, cnt_nx;
  logic             sat, sat_nx;
  logic             busy_nx, done_nx, ovf_nx;
  logic [15:0]      bcd_nx;
  logic [3:0]       blank_nx;
  logic [15:0]      adj, shifted;

  // All four nibbles are corrected in parallel on the pre-shift value.
  function automatic logic [15:0] add3(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (s[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Units digit is never blanked so a zero result still shows a single "0".
  function automatic logic [3:0] blank_mask(input logic [15:0] b);
    logic th, hu, te;
    th = (b[15:12] == 4'd0);
    hu = th & (b[11:8] == 4'd0);
    te = hu & (b[7:4] == 4'd0);
    return {th, hu, te, 1'b0};
  endfunction
`endif

  always_comb begin
    state_nx   = state;
    opnd_nx    = opnd;
    scratch_nx = scratch;
    cnt_nx     = cnt;
    sat_nx     = sat;
    busy_nx    = busy;
    done_nx    = 1'b0;
    bcd_nx     = bcd_out;
    ovf_nx     = ovf;
    blank_nx   = blank;
    adj        = add3(scratch);
    shifted    = (adj << 1) | {15'b0, opnd[BIN_W-1]};

    case (state)
      IDLE: begin
        if (start) begin
          if (32'(bin_in) > MAX_BCD) begin
            opnd_nx = MAX_BCD[BIN_W-1:0];
            sat_nx  = 1'b1;
          end else begin
            opnd_nx = bin_in;
            sat_nx  = 1'b0;
          end
          scratch_nx = 16'h0000;
          cnt_nx     = CNT_INIT;
          busy_nx    = 1'b1;
          state_nx   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_nx = shifted;
        opnd_nx    = {opnd[BIN_W-2:0], 1'b0};
        cnt_nx     = cnt - 4'd1;
        // Outputs are only published on the last shift, never mid-conversion.
        if (cnt == 4'd1) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          bcd_nx   = shifted;
          ovf_nx   = sat;
`ifdef LEADING_ZERO_BLANK_EN
          blank_nx = blank_mask(shifted);
`else
          blank_nx = 4'b0000;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      opnd    <= '0;
      scratch <= 16'h0000;
      cnt     <= 4'd0;
      sat     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= 16'h0000;
      ovf     <= 1'b0;
      blank   <= 4'b0000;
    end else begin
      state   <= state_nx;
      opnd    <= opnd_nx;
      scratch <= scratch_nx;
      cnt     <= cnt_nx;
      sat     <= sat_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      bcd_out <= bcd_nx;
      ovf     <= ovf_nx;
      blank   <= blank_nx;
    end
  end

endmodule

// File: tb/tb_bin_to_bcd4.sv
// Scoreboard bench for bin_to_bcd4: stimulus pushes expected results, a monitor checks each done pulse.
module tb_bin_to_bcd4;

  localparam int BIN_W = 14;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [BIN_W-1:0] bin_in = '0;
  logic             busy, done, ovf;
  logic [15:0]      bcd_out;
  logic [3:0]       blank;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  blank;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  bin_to_bcd4 #(.BIN_W(BIN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf), .blank(blank)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: actual bcd=%h required=no done (cycle %0d)", bcd_out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("done_cycle", 32'(cyc), 32'(e.cyc));
        checkOutput("bcd_out", 32'(bcd_out), 32'(e.bcd));
        checkOutput("ovf", 32'(ovf), 32'(e.ovf));
        checkOutput("blank", 32'(blank), 32'(e.blank));
        checkOutput("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Called at a falling edge; the start is sampled on the following rising edge.
  task automatic applyStimulus(input logic [BIN_W-1:0] v, input logic [15:0] exp_bcd,
                               input logic exp_ovf, input logic [3:0] exp_blank_mac,
                               input logic accept);
    exp_t e;
    start  = 1'b1;
    bin_in = v;
    if (accept) begin
      e.bcd = exp_bcd;
      e.ovf = exp_ovf;
`ifdef LEADING_ZERO_BLANK_EN
      e.blank = exp_blank_mac;
`else
      e.blank = 4'b0000;
`endif
      e.cyc = cyc + 1 + BIN_W;
      sb.push_back(e);
    end
    @(negedge clk);
    start  = 1'b0;
    bin_in = BIN_W'($urandom_range(0, 16383));
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: actual=no done required=done within %0d cycles", budget);
    end
  endtask

  initial begin
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_bcd", 32'(bcd_out), 32'h0000);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    checkOutput("rst_blank", 32'(blank), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(14'd9625, 16'h9625, 1'b0, 4'b0000, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("busy_mid", 32'(busy), 32'd1);
    checkOutput("bcd_hold_mid", 32'(bcd_out), 32'h0000);
    waitDone(40);

    // Back-to-back: each start issued in the previous done cycle.
    applyStimulus(14'd9224, 16'h9224, 1'b0, 4'b0000, 1'b1);
    waitDone(40);
    applyStimulus(14'd9756, 16'h9756, 1'b0, 4'b0000, 1'b1);
    waitDone(40);
    applyStimulus(14'd9186, 16'h9186, 1'b0, 4'b0000, 1'b1);
    waitDone(40);
    @(negedge clk);

    applyStimulus(14'd12000, 16'h9999, 1'b1, 4'b0000, 1'b1);
    waitDone(40);
    applyStimulus(14'd0, 16'h0000, 1'b0, 4'b1110, 1'b1);
    waitDone(40);
    applyStimulus(14'd42, 16'h0042, 1'b0, 4'b1100, 1'b1);
    waitDone(40);
    applyStimulus(14'd7, 16'h0007, 1'b0, 4'b1110, 1'b1);
    waitDone(40);
    applyStimulus(14'd1005, 16'h1005, 1'b0, 4'b0000, 1'b1);
    waitDone(40);
    @(negedge clk);

    // Start while busy must be ignored.
    applyStimulus(14'd1234, 16'h1234, 1'b0, 4'b0000, 1'b1);
    repeat (4) @(negedge clk);
    applyStimulus(14'd5678, 16'h5678, 1'b0, 4'b0000, 1'b0);
    waitDone(40);
    repeat (20) @(negedge clk);

    // Reset mid-conversion aborts it and clears the outputs.
    applyStimulus(14'd9625, 16'h9625, 1'b0, 4'b0000, 1'b1);
    waitDone(40);
    @(negedge clk);
    applyStimulus(14'd4321, 16'h4321, 1'b0, 4'b0000, 1'b0);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_bcd", 32'(bcd_out), 32'h0000);
    checkOutput("abort_ovf", 32'(ovf), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd4.md
Name: bin_to_bcd4

Overview:
- Sequential shift-and-add-3 (double-dabble) converter from an unsigned binary value to four packed BCD digits.
- Sits directly upstream of the four-digit seven-segment multiplexer, which consumes bcd_out one nibble per digit.
- The producer of the value (counter, button-selected preset) pulses start; the display latches bcd_out on done.
- One conversion at a time: start/busy/done handshake, no queue.

Parameters:
BIN_W, 14, width of bin_in; legal range 4..14. Values above 9999 are only possible when BIN_W = 14.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  request conversion; sampled only when busy = 0
bin_in  input  BIN_W  unsigned binary operand; sampled on the same edge as an accepted start
busy  output  1  conversion in progress
done  output  1  one-cycle pulse; bcd_out/ovf/blank valid and updated on this cycle
bcd_out  output  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units
ovf  output  1  last conversion input exceeded 9999 and was saturated
blank  output  4  leading-zero blank mask, one bit per digit, same bit order as bcd_out nibbles

Behaviour:
- Reset (asynchronous, any time, including mid-conversion):
  - busy = 0, done = 0, bcd_out = 16'h0000, ovf = 0, blank = 4'b0000.
  - FSM returns to IDLE; shift register, scratch and bit counter are cleared.
  - A conversion in flight is aborted and produces no done.
- FSM states: IDLE, SHIFT.
- IDLE:
  - On a clock edge with start = 1, capture the operand. If bin_in > 9999, load 9999 and set internal sat flag; otherwise load bin_in and clear sat.
  - Clear the 16-bit BCD scratch, load bit counter = BIN_W, set busy = 1, go to SHIFT.
  - start = 0: hold all outputs.
- SHIFT, one operand bit per cycle:
  - For each scratch nibble >= 5, add 3 (all four nibbles evaluated in parallel on the pre-shift value).
  - Shift {scratch, operand} left by 1, MSB of operand entering scratch[0].
  - Decrement the bit counter.
- Final shift (counter reaches 0):
  - On the same edge, load bcd_out with the post-shift scratch, ovf <= sat, and blank per the optional feature.
  - done = 1 for exactly this cycle, busy = 0, go to IDLE.
- Latency: start accepted at edge E; busy = 1 for edges E..E+BIN_W-1; done = 1 and new bcd_out at edge E+BIN_W. Throughput is one conversion per BIN_W+1 cycles.
- start while busy = 1 is ignored; it is not queued and does not affect the in-flight conversion.
- start = 1 in the done cycle: FSM is already IDLE, so it is accepted; busy re-asserts on the next edge.
- bcd_out, ovf and blank hold their last values between conversions and during a conversion. They never show partial results.
- bin_in may change freely after the accepting edge.
- Every nibble of bcd_out is always in the range 0..9.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: blank updates on the done edge.
  - blank[3] = (thousands == 0)
  - blank[2] = blank[3] & (hundreds == 0)
  - blank[1] = blank[2] & (tens == 0)
  - blank[0] = 0 always, so a value of 0 displays a single "0".
- Not defined: blank is tied to 4'b0000 permanently. Port list and all other behaviour are unchanged.

Test Plan:
- Reset, then start with bin_in = 9625 -> busy high for 14 cycles, done pulse at edge E+14, bcd_out = 16'h9625, ovf = 0; with macro, blank = 4'b0000.
- Sequence 9224, 9756, 9186, issuing each start in the previous done cycle -> bcd_out = 16'h9224, 16'h9756, 16'h9186 at 15-cycle spacing, no lost requests.
- bin_in = 12000 (BIN_W = 14) -> bcd_out = 16'h9999, ovf = 1; a following conversion of 0 -> bcd_out = 16'h0000, ovf = 0; with macro, blank = 4'b1110.
- Start 1234, then pulse start with 5678 at edge E+5 -> the second request is ignored; done at E+14 with bcd_out = 16'h1234; no further done.
- Start 4321 after a prior result of 16'h9625, assert rst at edge E+7 -> immediately busy = 0, bcd_out = 16'h0000, ovf = 0; no done pulse appears within 20 cycles after rst is released.
- With macro: bin_in = 42 -> bcd_out = 16'h0042, blank = 4'b1100; bin_in = 7 -> blank = 4'b1110; bin_in = 1005 -> blank = 4'b0000.
